// File: rtl/predicate_writeback_queue.sv
// ---------------------------------------------------------------------------
// predicate_writeback_queue
//
// Collects predicate results from two producers and writes them, in order,
// into the predicate register file through its single write port.
//
// Producers: the compare unit drives port 0 and the predicate-logic unit
// drives port 1. When both ports fire in the same cycle, port 1 is the
// younger write. Accepted requests go into a small circular FIFO. One entry
// per cycle moves from the FIFO head into a registered output stage
// (wr_en/wr_addr/wr_data). The register file commits that write on the
// negedge inside the same cycle.
//
// Issue logic uses the pending mask to hold back readers of any predicate
// that still has a write queued or sitting in the output stage.
//
// Ports:
//   clk          single clock; all state changes on posedge
//   reset        synchronous, active-high; overrides everything else
//   flush        synchronous discard of queued and staged writes
//   req0_*       port 0 request (valid, target predicate, value)
//   req1_*       port 1 request (valid, target predicate, value)
//   in_ready     both ports may enqueue this cycle (from registered count)
//   wr_en        registered write strobe to the register file
//   wr_addr      registered write address
//   wr_data      registered write data
//   pending      bit i set while any queued or staged write targets pred i
//   count        FIFO occupancy 0..DEPTH, output stage not included
//
// DEPTH_BITS must be at least 1, so the FIFO holds at least two entries.
// ---------------------------------------------------------------------------
module predicate_writeback_queue #(
    parameter int REG_BITS   = 2,
    parameter int DEPTH_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     req0_valid,
    input  logic [REG_BITS-1:0]      req0_addr,
    input  logic                     req0_data,
    input  logic                     req1_valid,
    input  logic [REG_BITS-1:0]      req1_addr,
    input  logic                     req1_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [REG_BITS-1:0]      wr_addr,
    output logic                     wr_data,
    output logic [(1<<REG_BITS)-1:0] pending,
    output logic [DEPTH_BITS:0]      count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int PTR_W = DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    // Two free slots must be guaranteed before a cycle where both ports may
    // write. Because this limit is taken from the registered count alone,
    // there is no combinational path from req*_valid to in_ready.
    localparam logic [DEPTH_BITS:0]   READY_LIMIT = CNT_W'(DEPTH - 2);
    localparam logic [DEPTH_BITS:0]   MAX_COUNT   = CNT_W'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE     = PTR_W'(1);

    logic                  accept0;
    logic                  accept1;
    logic                  dequeue;
    logic [DEPTH_BITS-1:0] head;
    logic [DEPTH_BITS-1:0] tail;
    logic [DEPTH_BITS-1:0] slot1_idx;
    logic [DEPTH_BITS-1:0] head_next;
    logic [DEPTH_BITS-1:0] tail_next;
    logic [DEPTH_BITS:0]   count_next;
    logic [REG_BITS-1:0]   slot_addr [DEPTH];
    logic                  slot_data [DEPTH];
    logic [DEPTH-1:0]      slot_live;

    assign in_ready = (count <= READY_LIMIT);

    // Acceptance and pointer arithmetic.
    // Port 0 always takes the tail slot when it fires. Port 1 takes the
    // next slot when port 0 also fires, so it lands behind port 0 and its
    // write reaches the register file last. On a same-address collision the
    // port 1 value is therefore the one left in the file.
    always_comb begin
        accept0    = req0_valid && in_ready && !flush;
        accept1    = req1_valid && in_ready && !flush;
        dequeue    = (count != '0);
        slot1_idx  = accept0 ? (tail + PTR_ONE) : tail;
        head_next  = dequeue ? (head + PTR_ONE) : head;
        tail_next  = tail + PTR_W'(accept0) + PTR_W'(accept1);
        count_next = count + CNT_W'(accept0) + CNT_W'(accept1) - CNT_W'(dequeue);
    end

    // Pointer and occupancy registers.
    // Reset and flush both return the queue to empty, with the pointers
    // back at slot 0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // FIFO storage.
    // This storage needs no reset: an entry only becomes meaningful once
    // the count covers it. Under the in_ready rule the writes can never
    // land on a slot that is still live, including the head slot being
    // drained in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept0) begin
                slot_addr[tail] <= req0_addr;
                slot_data[tail] <= req0_data;
            end
            if (accept1) begin
                slot_addr[slot1_idx] <= req1_addr;
                slot_data[slot1_idx] <= req1_data;
            end
        end
    end

    // Output stage.
    // When the FIFO is empty the strobe drops, but the address and data
    // keep their last values. A flush kills only the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 1'b0;
        end else if (flush) begin
            wr_en <= 1'b0;
        end else begin
            wr_en <= dequeue;
            if (dequeue) begin
                wr_addr <= slot_addr[head];
                wr_data <= slot_data[head];
            end
        end
    end

    // Live-slot mask.
    // A slot is live when its distance from the head, taken modulo DEPTH,
    // is below the occupancy. That holds whether or not the live region
    // wraps past the end of the array.
    always_comb begin
        slot_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_live[i] = ({1'b0, PTR_W'(i) - head} < count);
        end
    end

    // Pending mask.
    // This is the OR of every live slot's target predicate plus the output
    // stage while it is strobing. A predicate therefore clears the cycle
    // after its last write leaves the output stage.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live[i]) begin
                pending[slot_addr[i]] = 1'b1;
            end
        end
        if (wr_en) begin
            pending[wr_addr] = 1'b1;
        end
    end

    // Occupancy must never exceed the number of physical slots.
    assert property (@(posedge clk) disable iff (reset) count <= MAX_COUNT);

endmodule

// File: tb/tb_predicate_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_predicate_writeback_queue
//
// Testbench for predicate_writeback_queue, using REG_BITS=2 and
// DEPTH_BITS=2 (so DEPTH=4).
//
// A queue-level reference model follows every clock edge. Each write the
// model expects to be accepted is pushed onto a scoreboard. On every
// negedge where wr_en is high, a monitor pops the scoreboard and compares
// the popped entry with wr_addr/wr_data. The scenario tasks check
// occupancy, in_ready, pending and the write strobe against the model.
// ---------------------------------------------------------------------------
module tb_predicate_writeback_queue;

    localparam int REG_BITS   = 2;
    localparam int DEPTH_BITS = 2;
    localparam int DEPTH      = 1 << DEPTH_BITS;
    localparam int NUM_REG    = 1 << REG_BITS;

    typedef struct packed {
        logic [REG_BITS-1:0] addr;
        logic                data;
    } entry_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic                req0_valid;
    logic [REG_BITS-1:0] req0_addr;
    logic                req0_data;
    logic                req1_valid;
    logic [REG_BITS-1:0] req1_addr;
    logic                req1_data;
    logic                in_ready;
    logic                wr_en;
    logic [REG_BITS-1:0] wr_addr;
    logic                wr_data;
    logic [NUM_REG-1:0]  pending;
    logic [DEPTH_BITS:0] count;

    // Reference model state: FIFO contents, the output stage, and the
    // scoreboard of writes not yet seen on the wr_* port.
    entry_t m_fifo[$];
    entry_t sb[$];
    entry_t m_stage;
    logic   m_stage_valid = 1'b0;
    entry_t mon_e;
    int     checks   = 0;
    int     failures = 0;
    bit     mon_on   = 1'b0;

    always #5 clk = ~clk;

    predicate_writeback_queue #(
        .REG_BITS   (REG_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pending    (pending),
        .count      (count)
    );

    // Expected pending mask, built from the model's FIFO and output stage.
    function automatic logic [NUM_REG-1:0] exp_pending();
        logic [NUM_REG-1:0] p;
        p = '0;
        foreach (m_fifo[i]) p[m_fifo[i].addr] = 1'b1;
        if (m_stage_valid) p[m_stage.addr] = 1'b1;
        return p;
    endfunction

    // Scoreboard monitor: each write the DUT emits must match the oldest
    // write the model has accepted.
    always @(negedge clk) begin
        if (mon_on && wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL wr_unexpected: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
                    failures++;
                    $display("[TB] FAIL wr_order: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             wr_addr, wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic set_req(input logic v0, input logic [REG_BITS-1:0] a0, input logic d0,
                           input logic v1, input logic [REG_BITS-1:0] a1, input logic d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Advance one clock. The model update uses the inputs held across the
    // edge. Control returns 1 time unit after the posedge, away from the
    // edge itself.
    task automatic tick();
        bit     rdy;
        entry_t e;
        rdy = (m_fifo.size() <= DEPTH - 2);
        @(posedge clk);
        if (reset) begin
            m_fifo.delete(); sb.delete(); m_stage_valid = 1'b0; m_stage = '0;
        end else if (flush) begin
            m_fifo.delete(); sb.delete(); m_stage_valid = 1'b0;
        end else begin
            if (m_fifo.size() > 0) begin
                m_stage = m_fifo.pop_front();
                m_stage_valid = 1'b1;
            end else begin
                m_stage_valid = 1'b0;
            end
            if (req0_valid && rdy) begin
                e.addr = req0_addr; e.data = req0_data;
                m_fifo.push_back(e); sb.push_back(e);
            end
            if (req1_valid && rdy) begin
                e.addr = req1_addr; e.data = req1_data;
                m_fifo.push_back(e); sb.push_back(e);
            end
        end
        #1;
    endtask

    // Run the queue empty within a bounded number of cycles, then confirm
    // the DUT has emitted every accepted write.
    task automatic drain(input string tag);
        for (int i = 0; i < 8 && (m_fifo.size() > 0 || m_stage_valid); i++) tick();
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL %s_lost: got %0d writes missing, required 0", tag, sb.size()); end
        checks++; if (count !== '0) begin failures++; $display("[TB] FAIL %s_drain_count: got %0d required 0", tag, count); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL %s_drain_wr_en: got %0b required 0", tag, wr_en); end
    endtask

    // Bring the DUT to count=3 with an entry in the output stage.
    task automatic fill_to_three();
        set_req(1'b1, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0);
        tick();
        set_req(1'b1, 2'd2, 1'b0, 1'b1, 2'd3, 1'b1);
        tick();
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        mon_on = 1'b1;
        checks++; if (count !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d required 0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en: got %0b required 0", wr_en); end
        checks++; if (wr_addr !== '0) begin failures++; $display("[TB] FAIL reset_wr_addr: got %0d required 0", wr_addr); end
        checks++; if (wr_data !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_data: got %0b required 0", wr_data); end
        checks++; if (pending !== '0) begin failures++; $display("[TB] FAIL reset_pending: got %b required 0000", pending); end
    endtask

    task automatic test_single_write();
        set_req(1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL single_count: got %0d required 1", count); end
        checks++; if (pending !== 4'b0100) begin failures++; $display("[TB] FAIL single_pending_q: got %b required 0100", pending); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL single_wr_en_early: got %0b required 0", wr_en); end
        tick();
        checks++; if (wr_en !== 1'b1) begin failures++; $display("[TB] FAIL single_wr_en: got %0b required 1", wr_en); end
        checks++; if (wr_addr !== 2'd2) begin failures++; $display("[TB] FAIL single_wr_addr: got %0d required 2", wr_addr); end
        checks++; if (wr_data !== 1'b1) begin failures++; $display("[TB] FAIL single_wr_data: got %0b required 1", wr_data); end
        checks++; if (pending !== 4'b0100) begin failures++; $display("[TB] FAIL single_pending_stage: got %b required 0100", pending); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL single_wr_en_done: got %0b required 0", wr_en); end
        checks++; if (pending !== 4'b0000) begin failures++; $display("[TB] FAIL single_pending_clear: got %b required 0000", pending); end
        checks++; if (wr_addr !== 2'd2) begin failures++; $display("[TB] FAIL single_wr_addr_hold: got %0d required 2", wr_addr); end
    endtask

    task automatic test_same_addr();
        set_req(1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0);
        tick();
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL same_count: got %0d required 2", count); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("[TB] FAIL same_pending_q: got %b required 0010", pending); end
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 1'b1) begin failures++;
            $display("[TB] FAIL same_first: got en=%0b addr=%0d data=%0b required en=1 addr=1 data=1", wr_en, wr_addr, wr_data); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("[TB] FAIL same_pending_1: got %b required 0010", pending); end
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== 1'b0) begin failures++;
            $display("[TB] FAIL same_second: got en=%0b addr=%0d data=%0b required en=1 addr=1 data=0", wr_en, wr_addr, wr_data); end
        checks++; if (pending !== 4'b0010) begin failures++; $display("[TB] FAIL same_pending_2: got %b required 0010", pending); end
        tick();
        checks++; if (wr_en !== 1'b0 || pending !== 4'b0000) begin failures++;
            $display("[TB] FAIL same_done: got en=%0b pending=%b required en=0 pending=0000", wr_en, pending); end
    endtask

    // Both ports request every cycle. A request that is not accepted is
    // held with the same values until it is.
    task automatic test_back_to_back();
        entry_t a0, a1;
        bit     rdy_exp;
        bit     saw_three = 1'b0;
        bit     saw_stall = 1'b0;
        a0 = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
        a1 = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
        for (int i = 0; i < 14; i++) begin
            set_req(1'b1, a0.addr, a0.data, 1'b1, a1.addr, a1.data);
            rdy_exp = (m_fifo.size() <= DEPTH - 2);
            checks++; if (in_ready !== rdy_exp) begin failures++; $display("[TB] FAIL b2b_in_ready: got %0b required %0b", in_ready, rdy_exp); end
            if (in_ready === 1'b0) saw_stall = 1'b1;
            tick();
            if (rdy_exp) begin
                a0 = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
                a1 = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            end
            if (count === 3'd3) saw_three = 1'b1;
            checks++; if (count !== 3'(m_fifo.size())) begin failures++; $display("[TB] FAIL b2b_count: got %0d required %0d", count, m_fifo.size()); end
            checks++; if (wr_en !== m_stage_valid) begin failures++; $display("[TB] FAIL b2b_wr_en: got %0b required %0b", wr_en, m_stage_valid); end
            checks++; if (pending !== exp_pending()) begin failures++; $display("[TB] FAIL b2b_pending: got %b required %b", pending, exp_pending()); end
        end
        checks++; if (!saw_three) begin failures++; $display("[TB] FAIL b2b_peak: got no count=3, required count=3 reached"); end
        checks++; if (!saw_stall) begin failures++; $display("[TB] FAIL b2b_stall: got in_ready never low, required a stall"); end
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        drain("b2b");
    endtask

    task automatic test_full_stall();
        fill_to_three();
        checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL stall_fill: got %0d required 3", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready_low: got %0b required 0", in_ready); end
        set_req(1'b1, 2'd3, 1'b0, 1'b1, 2'd2, 1'b1);
        tick();
        checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL stall_dropped: got %0d required 2", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_ready_high: got %0b required 1", in_ready); end
        tick();
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL stall_resume: got %0d required 3", count); end
        drain("stall");
    endtask

    task automatic test_flush();
        fill_to_three();
        checks++; if (count !== 3'd3 || wr_en !== 1'b1) begin failures++;
            $display("[TB] FAIL flush_setup: got count=%0d en=%0b required count=3 en=1", count, wr_en); end
        flush = 1'b1;
        set_req(1'b1, 2'd3, 1'b1, 1'b1, 2'd3, 1'b0);
        tick();
        flush = 1'b0;
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (count !== '0) begin failures++; $display("[TB] FAIL flush_count: got %0d required 0", count); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL flush_wr_en: got %0b required 0", wr_en); end
        checks++; if (pending !== '0) begin failures++; $display("[TB] FAIL flush_pending: got %b required 0000", pending); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_in_ready: got %0b required 1", in_ready); end
        tick(); tick(); tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("[TB] FAIL flush_quiet: got %0b required 0", wr_en); end
    endtask

    task automatic test_reset_mid_drain();
        fill_to_three();
        reset = 1'b1; flush = 1'b1;
        set_req(1'b1, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1);
        tick();
        reset = 1'b0; flush = 1'b0;
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (count !== '0 || in_ready !== 1'b1) begin failures++;
            $display("[TB] FAIL rmid_count: got count=%0d rdy=%0b required count=0 rdy=1", count, in_ready); end
        checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 1'b0) begin failures++;
            $display("[TB] FAIL rmid_wr: got en=%0b addr=%0d data=%0b required all 0", wr_en, wr_addr, wr_data); end
        checks++; if (pending !== '0) begin failures++; $display("[TB] FAIL rmid_pending: got %b required 0000", pending); end
        set_req(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        set_req(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (count !== 3'd1 || pending !== 4'b1000) begin failures++;
            $display("[TB] FAIL rmid_enq: got count=%0d pending=%b required count=1 pending=1000", count, pending); end
        tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 2'd3 || wr_data !== 1'b0) begin failures++;
            $display("[TB] FAIL rmid_write: got en=%0b addr=%0d data=%0b required en=1 addr=3 data=0", wr_en, wr_addr, wr_data); end
        tick();
        checks++; if (wr_en !== 1'b0 || pending !== '0) begin failures++;
            $display("[TB] FAIL rmid_done: got en=%0b pending=%b required en=0 pending=0000", wr_en, pending); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_same_addr();
        test_back_to_back();
        test_full_stall();
        test_flush();
        test_reset_mid_drain();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion, required finish within 200000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
